voice_allocator: RTL
====================

// Module: voice_allocator
// PURPOSE
//  Polyphonic voice manager between the MIDI note-event decoder and an array of
//  NUM_VOICES voice instances. It accepts note-on and note-off events and assigns
//  each note to a voice. It drives every voice's gate (enable) and midi_data.
//  Its steal and retrigger policy produces clean ADSR re-attacks.
// PARAMETERS
//  NUM_VOICES     4   number of voices managed (>=2)
//  NOTE_BITS      8   width of the note number; matches voice midi_data
//  AGE_BITS       8   per-voice saturating age counter width
//  RETRIG_CYCLES  16  clk cycles a gate is held low before a retrigger re-asserts it (>=1)
// PORTS
//  clk          in   1                      system clock
//  rst          in   1                      synchronous, active-high reset
//  note_valid   in   1                      event request
//  note_ready   out  1                      allocator can accept an event
//  note_on      in   1                      1 = note-on, 0 = note-off
//  note         in   NOTE_BITS              note number of the event
//  panic        in   1                      all-notes-off
//  voice_gate   out  NUM_VOICES             per-voice gate, drives voice enable
//  voice_note   out  NUM_VOICES*NOTE_BITS   per-voice note; voice i = bits [i*NOTE_BITS +: NOTE_BITS]
//  busy         out  1                      high in SCAN or COMMIT
// BEHAVIOUR
//  One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
//  Reset values:
//   - voice_gate = 0, voice_note = 0, all ages = all-ones (saturated), retrigger counters = 0.
//   - state = IDLE, busy = 0.
//   - note_ready = 0 while rst is high and 1 the cycle after.
//  Handshake: an event is accepted when note_valid & note_ready. note_ready = (state==IDLE) & ~rst.
//  FSM IDLE -> SCAN -> COMMIT -> IDLE:
//   - IDLE: on accept, latch note_on and note; scan index i = 0.
//   - SCAN: exactly NUM_VOICES cycles, one voice per cycle in index order. Three candidates are
//     tracked: first same-note voice; free voice (gate=0) with max age; gated voice with max age.
//     Age ties resolve to the lowest index.
//   - COMMIT: 1 cycle; registers are updated. Results are visible and note_ready = 1 on the next cycle.
//  Latency: accept at cycle 0; outputs change and note_ready returns at cycle NUM_VOICES+2.
//  Note-on target priority:
//   1. same-note voice
//   2. oldest free voice
//   3. oldest gated voice (steal)
//  Note-on commit:
//   - Target voice_note <= note; target age <= 0; every other age += 1, saturating at all-ones.
//   - Target gate was 0: gate <= 1 at commit.
//   - Target gate was 1 (same-note or steal): retrigger. Gate <= 0 for RETRIG_CYCLES cycles,
//     then 1. The per-voice retrigger counter runs independently of the FSM.
//   - A new retrigger on a voice already retriggering restarts its counter.
//  Note-off commit:
//   - Every voice with matching note and (gate=1 or retriggering) gets gate <= 0 and its
//     retrigger is cancelled.
//   - voice_note and ages are unchanged.
//   - A note-off matching no voice is a no-op but still takes the full latency.
//  panic:
//   - Highest priority, any state.
//   - Next cycle: all gates = 0, all retriggers cancelled, state = IDLE, note_ready = 1.
//   - Any in-flight event is dropped; voice_note and ages are kept.
//  rst asserted mid-operation restores all reset values on the next edge and drops the pending event.
//  note_valid while not ready: the event is held off, not lost; the source must keep it stable.
//  Width rules:
//   - Scan index is $clog2(NUM_VOICES) bits.
//   - Retrigger counter is $clog2(RETRIG_CYCLES+1) bits.
//   - Age compare is unsigned.
// STRUCTURE
//  Shared header voice_alloc_defs.vh holds:
//   - FSM state encodings (ST_IDLE, ST_SCAN, ST_COMMIT)
//   - an event-type localparam
//  Sub-module retrig_gate (one per voice, generate loop):
//   - inputs: clk, rst, set, start_retrig, clear
//   - output: gate
//   - contains the RETRIG_CYCLES down-counter
//  The scan/compare/age logic stays in voice_allocator.
// TESTING
//  1. Reset, note-on 60 -> voice0 gate=1 note=60 at cycle NUM_VOICES+2; note_ready low cycles 1..NUM_VOICES+1.
//  2. Note-on 60,64,67,71 -> voices 0..3. Note-on 72 -> voice0 stolen: gate0 low 16 cycles then high,
//     note0=72; voices 1..3 unchanged.
//  3. Note-off 64 -> gate1=0, others held. Note-on 76 -> voice1 (only free voice), no retrigger.
//  4. Note-on 67 while held -> voice2 retrigger (gate2 low 16 cycles); no other gate or note changes.
//  5. Note-off 67 during that retrigger -> gate2 stays 0 after 16 cycles. Note-off 99 (unheld)
//     -> no output change.
//  6. panic mid-SCAN -> all gates 0 and note_ready=1 next cycle; rst mid-SCAN -> all reset values.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// ---------------------------------------------------------------------------
// voice_allocator_pkg
// Shared definitions for the polyphonic voice allocator:
//   - state_t      : allocator FSM states (idle, scanning voices, committing)
//   - EV_NOTE_ON   : event-type encoding of a note-on event
//   - EV_NOTE_OFF  : event-type encoding of a note-off event
// No ports; imported by voice_allocator and its sub-modules.
// ---------------------------------------------------------------------------
package voice_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic EV_NOTE_ON  = 1'b1;
  localparam logic EV_NOTE_OFF = 1'b0;

endpackage

// File: rtl/voice_allocator_retrig_gate.sv
// ---------------------------------------------------------------------------
// voice_allocator_retrig_gate
// Per-voice gate register with a retrigger timer. A retrigger drops the gate
// for RETRIG_CYCLES clocks and then raises it again, so the voice's envelope
// sees a clean release/attack edge.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   set           in   raise the gate immediately (voice was free)
//   start_retrig  in   drop the gate and (re)start the retrigger timer
//   clear         in   drop the gate and cancel any pending retrigger
//   gate          out  registered gate for the voice
//   retriggering  out  high while the retrigger timer is running
// ---------------------------------------------------------------------------
module voice_allocator_retrig_gate #(
  parameter int RETRIG_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic start_retrig,
  input  logic clear,
  output logic gate,
  output logic retriggering
);

  localparam int CNT_BITS = $clog2(RETRIG_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(RETRIG_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  logic                r_gate;
  logic [CNT_BITS-1:0] r_cnt;

  // Clear wins over everything so a note-off or panic can never be undone by
  // a retrigger expiring on the same edge. While the counter runs the gate is
  // held low; the edge that moves the counter from 1 to 0 raises it again,
  // giving exactly RETRIG_CYCLES low cycles after the retrigger edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate <= 1'b0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_gate <= 1'b0;
      r_cnt  <= '0;
    end else if (start_retrig) begin
      r_gate <= 1'b0;
      r_cnt  <= CNT_LOAD;
    end else if (set) begin
      r_gate <= 1'b1;
      r_cnt  <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_ONE;
      if (r_cnt == CNT_ONE) begin
        r_gate <= 1'b1;
      end
    end
  end

  assign gate         = r_gate;
  assign retriggering = (r_cnt != '0);

endmodule

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
// Polyphonic voice manager. Accepts note-on/note-off events, scans the voices
// one per cycle to pick a target (same note, else oldest free, else oldest
// held voice is stolen) and drives each voice's gate and note number.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   note_valid  in   event request
//   note_ready  out  allocator can accept an event (idle and not in reset)
//   note_on     in   1 = note-on, 0 = note-off
//   note        in   note number of the event
//   panic       in   all-notes-off, highest priority
//   voice_gate  out  per-voice gate
//   voice_note  out  per-voice note, voice i at [i*NOTE_BITS +: NOTE_BITS]
//   busy        out  high while scanning or committing
// ---------------------------------------------------------------------------
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES    = 4,
  parameter int NOTE_BITS     = 8,
  parameter int AGE_BITS      = 8,
  parameter int RETRIG_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            note_valid,
  output logic                            note_ready,
  input  logic                            note_on,
  input  logic [NOTE_BITS-1:0]            note,
  input  logic                            panic,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic                            busy
);

  localparam int IDX_BITS = $clog2(NUM_VOICES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VOICES - 1);
  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);
  localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;
  localparam logic [AGE_BITS-1:0] AGE_ONE  = AGE_BITS'(1);

  // FSM and scan state
  state_t                r_state;
  logic                  r_busy;
  logic                  r_evOn;
  logic [NOTE_BITS-1:0]  r_evNote;
  logic [IDX_BITS-1:0]   r_scanIdx;
  logic                  r_sameFound;
  logic [IDX_BITS-1:0]   r_sameIdx;
  logic                  r_freeFound;
  logic [IDX_BITS-1:0]   r_freeIdx;
  logic [AGE_BITS-1:0]   r_freeAge;
  logic                  r_heldFound;
  logic [IDX_BITS-1:0]   r_heldIdx;
  logic [AGE_BITS-1:0]   r_heldAge;
  logic [NUM_VOICES-1:0] r_matchMask;

  // Per-voice storage
  logic [NUM_VOICES-1:0][NOTE_BITS-1:0] r_voiceNote;
  logic [NUM_VOICES-1:0][AGE_BITS-1:0]  r_age;

  // Gate-cell interface
  logic [NUM_VOICES-1:0] w_gate;
  logic [NUM_VOICES-1:0] w_retrig;
  logic [NUM_VOICES-1:0] w_held;
  logic [NUM_VOICES-1:0] w_set;
  logic [NUM_VOICES-1:0] w_startRetrig;
  logic [NUM_VOICES-1:0] w_clear;

  logic                  w_commit;
  logic [IDX_BITS-1:0]   w_target;
  logic [NOTE_BITS-1:0]  w_curNote;
  logic [AGE_BITS-1:0]   w_curAge;
  logic                  w_curHeld;

  // A voice counts as held while its gate is up or a retrigger is pending;
  // a retriggering voice is still sounding a note and must not look free.
  assign w_held    = w_gate | w_retrig;
  assign w_curNote = r_voiceNote[r_scanIdx];
  assign w_curAge  = r_age[r_scanIdx];
  assign w_curHeld = w_held[r_scanIdx];

  assign note_ready = (r_state == ST_IDLE) & ~rst;
  assign busy       = r_busy;
  assign voice_gate = w_gate;
  assign voice_note = r_voiceNote;

  // Main FSM: latch the event, walk the voices one per cycle tracking the
  // three candidates, then spend one cycle committing. Strict greater-than
  // on age keeps the lowest index on ties. Panic drops any in-flight event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_evOn      <= EV_NOTE_OFF;
      r_evNote    <= '0;
      r_scanIdx   <= '0;
      r_sameFound <= 1'b0;
      r_sameIdx   <= '0;
      r_freeFound <= 1'b0;
      r_freeIdx   <= '0;
      r_freeAge   <= '0;
      r_heldFound <= 1'b0;
      r_heldIdx   <= '0;
      r_heldAge   <= '0;
      r_matchMask <= '0;
    end else if (panic) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (note_valid) begin
            r_evOn      <= note_on;
            r_evNote    <= note;
            r_scanIdx   <= '0;
            r_sameFound <= 1'b0;
            r_freeFound <= 1'b0;
            r_heldFound <= 1'b0;
            r_matchMask <= '0;
            r_state     <= ST_SCAN;
            r_busy      <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_curNote == r_evNote) begin
            r_matchMask[r_scanIdx] <= 1'b1;
            if (!r_sameFound) begin
              r_sameFound <= 1'b1;
              r_sameIdx   <= r_scanIdx;
            end
          end
          if (!w_curHeld) begin
            if (!r_freeFound || (w_curAge > r_freeAge)) begin
              r_freeFound <= 1'b1;
              r_freeIdx   <= r_scanIdx;
              r_freeAge   <= w_curAge;
            end
          end else begin
            if (!r_heldFound || (w_curAge > r_heldAge)) begin
              r_heldFound <= 1'b1;
              r_heldIdx   <= r_scanIdx;
              r_heldAge   <= w_curAge;
            end
          end
          if (r_scanIdx == LAST_IDX) begin
            r_state <= ST_COMMIT;
          end else begin
            r_scanIdx <= r_scanIdx + IDX_ONE;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Commit decode: choose the target by priority and turn the latched event
  // into per-voice gate commands. Panic overrides with a clear on every voice.
  // With at least two voices every voice is either free or held, so a target
  // always exists.
  always_comb begin
    w_target = r_heldIdx;
    if (r_sameFound) begin
      w_target = r_sameIdx;
    end else if (r_freeFound) begin
      w_target = r_freeIdx;
    end
    w_commit      = (r_state == ST_COMMIT) & ~panic & ~rst;
    w_set         = '0;
    w_startRetrig = '0;
    w_clear       = '0;
    if (w_commit) begin
      if (r_evOn == EV_NOTE_ON) begin
        if (w_held[w_target]) begin
          w_startRetrig[w_target] = 1'b1;
        end else begin
          w_set[w_target] = 1'b1;
        end
      end else begin
        w_clear = r_matchMask & w_held;
      end
    end
    if (panic) begin
      w_clear = '1;
    end
  end

  // Note numbers and ages only move on a note-on commit: the target takes
  // the new note with age zero and every other voice ages by one, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_voiceNote <= '0;
      r_age       <= '1;
    end else if (w_commit && (r_evOn == EV_NOTE_ON)) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_BITS'(i) == w_target) begin
          r_voiceNote[i] <= r_evNote;
          r_age[i]       <= '0;
        end else if (r_age[i] != AGE_MAX) begin
          r_age[i] <= r_age[i] + AGE_ONE;
        end
      end
    end
  end

  // One gate cell per voice holds the gate and its retrigger timer.
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_allocator_retrig_gate #(
      .RETRIG_CYCLES(RETRIG_CYCLES)
    ) u_retrigGate (
      .clk         (clk),
      .rst         (rst),
      .set         (w_set[g]),
      .start_retrig(w_startRetrig[g]),
      .clear       (w_clear[g]),
      .gate        (w_gate[g]),
      .retriggering(w_retrig[g])
    );
  end

endmodule
